// File: rtl/wt_cache_pkg.sv
// Shared types for the dcache miss arbiter: core config subset, miss request struct, arbiter state.
package wt_cache_pkg;

   typedef struct packed {
      int unsigned PLEN;
      int unsigned DCACHE_SET_ASSOC;
      int unsigned MEM_TID_WIDTH;
      int unsigned WID_WIDTH;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{
      PLEN: 34, DCACHE_SET_ASSOC: 4, MEM_TID_WIDTH: 4, WID_WIDTH: 2
   };

   localparam int unsigned MissPlen     = cva6_cfg_empty.PLEN;
   localparam int unsigned MissSetAssoc = cva6_cfg_empty.DCACHE_SET_ASSOC;
   localparam int unsigned MissWidW     = cva6_cfg_empty.WID_WIDTH;

   typedef struct packed {
      logic [MissPlen-1:0]     paddr;
      logic [2:0]              size;
      logic                    nc;
      logic [MissSetAssoc-1:0] vld_bits;
      logic [MissWidW-1:0]     wid;
   } miss_req_t;

   typedef enum logic {IDLE, LOCKED} arb_state_e;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// Wrap-around priority pick: lowest requester at or above ptr_i, else lowest requester overall.
module wt_dcache_rr_pick #(
   parameter  int unsigned N    = 3,
   localparam int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic            vld_o,
   output logic [IdxW-1:0] idx_o
);

   logic [N-1:0]    masked;
   logic [IdxW-1:0] masked_idx;
   logic [IdxW-1:0] any_idx;

   always_comb begin
      masked     = '0;
      masked_idx = '0;
      any_idx    = '0;
      for (int i = 0; i < N; i++) begin
         masked[i] = req_i[i] && (IdxW'(i) >= ptr_i);
      end
      // Descending scan leaves the lowest set index behind
      for (int i = N - 1; i >= 0; i--) begin
         if (masked[i]) masked_idx = IdxW'(i);
         if (req_i[i])  any_idx    = IdxW'(i);
      end
      vld_o = |req_i;
      idx_o = (|masked) ? masked_idx : any_idx;
   end

endmodule

// File: rtl/wt_dcache_miss_arb.sv
// Round-robin arbiter from the dcache read-port controllers onto the single miss-unit request port,
// with per-port outstanding-miss tracking and return routing by transaction ID.
module wt_dcache_miss_arb
   import wt_cache_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg  = cva6_cfg_empty,
   parameter int unsigned NumPorts = 3,
   parameter int unsigned BaseTxId = 1,
   localparam int unsigned TidW    = CVA6Cfg.MEM_TID_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumPorts-1:0] port_req_i,
   output logic [NumPorts-1:0] port_ack_o,
   output logic [NumPorts-1:0] port_replay_o,
   output logic [NumPorts-1:0] port_rtrn_vld_o,
   input  miss_req_t           port_miss_i [NumPorts],
   output logic                miss_req_o,
   input  logic                miss_ack_i,
   input  logic                miss_replay_i,
   output miss_req_t           miss_o,
   output logic [TidW-1:0]     miss_id_o,
   input  logic                miss_rtrn_vld_i,
   input  logic [TidW-1:0]     miss_rtrn_id_i
);

   localparam int unsigned IdxW = $clog2(NumPorts);

   arb_state_e          state_q;
   logic [IdxW-1:0]     rr_ptr_q;
   logic [IdxW-1:0]     lock_idx_q;
   logic [NumPorts-1:0] pending_q;
   logic [NumPorts-1:0] pending_d;

   logic                pick_vld;
   logic [IdxW-1:0]     pick_idx;
   logic [IdxW-1:0]     sel_idx;
   logic [IdxW-1:0]     next_ptr;
   logic                resp;

   // Ports with a miss in flight are kept out of arbitration
   wt_dcache_rr_pick #(
      .N (NumPorts)
   ) i_rr_pick (
      .req_i (port_req_i & ~pending_q),
      .ptr_i (rr_ptr_q),
      .vld_o (pick_vld),
      .idx_o (pick_idx)
   );

   always_comb begin
      sel_idx         = (state_q == LOCKED) ? lock_idx_q : pick_idx;
      miss_req_o      = (state_q == LOCKED) || pick_vld;
      miss_o          = miss_req_o ? port_miss_i[sel_idx] : '0;
      miss_id_o       = miss_req_o ? (TidW'(BaseTxId) + TidW'(sel_idx)) : '0;
      resp            = miss_req_o && (miss_ack_i || miss_replay_i);
      next_ptr        = IdxW'(wrap_inc(int'(sel_idx), NumPorts));
      port_ack_o      = '0;
      port_replay_o   = '0;
      port_rtrn_vld_o = '0;
      // Replay has priority over a simultaneous ack
      if (resp) begin
         if (miss_replay_i) port_replay_o[sel_idx] = 1'b1;
         else               port_ack_o[sel_idx]    = 1'b1;
      end
      for (int unsigned i = 0; i < NumPorts; i++) begin
         port_rtrn_vld_o[i] = miss_rtrn_vld_i && pending_q[i]
                              && (miss_rtrn_id_i == TidW'(BaseTxId + i));
      end
      pending_d = (pending_q & ~port_rtrn_vld_o) | port_ack_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         pending_q  <= '0;
      end else begin
         pending_q <= pending_d;
         unique case (state_q)
            IDLE: begin
               if (resp) begin
                  rr_ptr_q <= next_ptr;
               end else if (pick_vld) begin
                  lock_idx_q <= pick_idx;
                  state_q    <= LOCKED;
               end
            end
            LOCKED: begin
               if (resp) begin
                  rr_ptr_q <= next_ptr;
                  state_q  <= IDLE;
               end
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(state_q == LOCKED && !port_req_i[lock_idx_q]))
            else $error("miss_arb: port %0d dropped its request while locked", lock_idx_q);
         assert ((port_req_i & pending_q) == '0)
            else $error("miss_arb: request from port with outstanding miss (%b)", port_req_i & pending_q);
         assert (!(miss_rtrn_vld_i && port_rtrn_vld_o == '0))
            else $warning("miss_arb: return id %0d matches no outstanding miss", miss_rtrn_id_i);
      end
   end
`endif

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Directed and randomized bench for wt_dcache_miss_arb against a rule-level reference model.
module tb_wt_dcache_miss_arb;
   import wt_cache_pkg::*;

   localparam int N    = 3;
   localparam int TidW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    port_ack_o, port_replay_o, port_rtrn_vld_o;
   miss_req_t       pmiss [N];
   logic            miss_req_o;
   logic            ack = 1'b0, rep = 1'b0;
   miss_req_t       miss_o;
   logic [TidW-1:0] miss_id_o;
   logic            rvld = 1'b0;
   logic [TidW-1:0] rid = '0;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit        m_locked;
   int        m_lock;
   int        m_ptr;
   bit [N-1:0] m_pend;
   logic [N-1:0] last_ack, last_rep;

   // values observed in the most recent cycle
   logic [N-1:0]    obs_ack, obs_rep, obs_rtrn;
   logic [TidW-1:0] obs_id;
   miss_req_t       obs_miss;

   always #5 clk = ~clk;

   wt_dcache_miss_arb dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .port_req_i      (req),
      .port_ack_o      (port_ack_o),
      .port_replay_o   (port_replay_o),
      .port_rtrn_vld_o (port_rtrn_vld_o),
      .port_miss_i     (pmiss),
      .miss_req_o      (miss_req_o),
      .miss_ack_i      (ack),
      .miss_replay_i   (rep),
      .miss_o          (miss_o),
      .miss_id_o       (miss_id_o),
      .miss_rtrn_vld_i (rvld),
      .miss_rtrn_id_i  (rid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic rand_fields();
      for (int i = 0; i < N; i++) begin
         pmiss[i].paddr    = {$urandom, $urandom};
         pmiss[i].size     = 3'($urandom);
         pmiss[i].nc       = 1'($urandom);
         pmiss[i].vld_bits = 4'($urandom);
         pmiss[i].wid      = 2'($urandom);
      end
   endtask

   task automatic clear_inputs();
      req = '0; ack = 1'b0; rep = 1'b0; rvld = 1'b0; rid = '0;
   endtask

   // One clock: compare combinational outputs at the falling edge, then advance the model
   task automatic cycle();
      int        sel;
      bit        mreq, resp;
      logic [N-1:0] e_ack, e_rep, e_rtrn;
      miss_req_t e_miss;
      @(negedge clk);
      sel = 0; mreq = 0;
      if (m_locked) begin
         sel = m_lock; mreq = 1;
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            if (req[(m_ptr + k) % N] && !m_pend[(m_ptr + k) % N]) begin
               sel = (m_ptr + k) % N; mreq = 1;
            end
         end
      end
      resp  = mreq && (ack || rep);
      e_ack = '0; e_rep = '0; e_rtrn = '0;
      if (resp && rep)  e_rep[sel] = 1'b1;
      if (resp && !rep) e_ack[sel] = 1'b1;
      for (int i = 0; i < N; i++)
         e_rtrn[i] = rvld && (int'(rid) == 1 + i) && m_pend[i];
      e_miss = mreq ? pmiss[sel] : '0;
      obs_ack = port_ack_o; obs_rep = port_replay_o; obs_rtrn = port_rtrn_vld_o;
      obs_id = miss_id_o; obs_miss = miss_o;
      chk("miss_req", miss_req_o, mreq);
      chk("miss_id", miss_id_o, mreq ? 1 + sel : 0);
      chk("miss_o", miss_o, e_miss);
      chk("port_ack", port_ack_o, e_ack);
      chk("port_replay", port_replay_o, e_rep);
      chk("port_rtrn", port_rtrn_vld_o, e_rtrn);
      @(posedge clk);
      m_pend = (m_pend & ~e_rtrn) | e_ack;
      if (resp) begin
         m_ptr = (sel + 1) % N; m_locked = 0;
      end else if (mreq && !m_locked) begin
         m_locked = 1; m_lock = sel;
      end
      last_ack = e_ack; last_rep = e_rep;
      #1;
      chk("pending", dut.pending_q, m_pend);
      chk("rr_ptr", dut.rr_ptr_q, m_ptr);
      chk("locked", dut.state_q == LOCKED, m_locked);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      m_locked = 0; m_lock = 0; m_ptr = 0; m_pend = '0;
      #1;
      chk("rst_ack", port_ack_o, 0);
      chk("rst_replay", port_replay_o, 0);
      chk("rst_rtrn", port_rtrn_vld_o, 0);
      chk("rst_miss_req", miss_req_o, 0);
      chk("rst_miss_id", miss_id_o, 0);
      chk("rst_pending", dut.pending_q, 0);
      chk("rst_state", dut.state_q == LOCKED, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rand_fields();
      @(posedge clk);
      #1;
      // 1: single request acked in the same cycle
      do_reset();
      req = 3'b010; ack = 1'b1;
      cycle();
      chk("t1_ack", obs_ack, 3'b010);
      chk("t1_id", obs_id, 2);
      chk("t1_pending", dut.pending_q, 3'b010);
      chk("t1_ptr", dut.rr_ptr_q, 2);

      // 2: fairness, returns issued right away so every port can come back
      do_reset();
      req = 3'b111; ack = 1'b1;
      cycle();
      chk("t2_g0", obs_ack, 3'b001);
      req = 3'b110; rvld = 1'b1; rid = 4'd1;
      cycle();
      chk("t2_g1", obs_ack, 3'b010);
      req = 3'b101; rid = 4'd2;
      cycle();
      chk("t2_g2", obs_ack, 3'b100);
      req = 3'b011; rid = 4'd3;
      cycle();
      chk("t2_g3", obs_ack, 3'b001);
      chk("t2_rtrn", obs_rtrn, 3'b100);

      // 3: held grant while the ack is delayed
      do_reset();
      rand_fields();
      req = 3'b101;
      for (int c = 0; c < 5; c++) begin
         ack = (c == 4);
         cycle();
         chk("t3_paddr", obs_miss.paddr, pmiss[0].paddr);
      end
      chk("t3_ack", obs_ack, 3'b001);
      req = 3'b100; ack = 1'b0;
      cycle();
      chk("t3_next_id", obs_id, 3);

      // 4: replay wins over ack
      do_reset();
      req = 3'b001; ack = 1'b1; rep = 1'b1;
      cycle();
      chk("t4_replay", obs_rep, 3'b001);
      chk("t4_ack", obs_ack, 3'b000);
      chk("t4_pending", dut.pending_q, 3'b000);

      // 5: ack and unrelated return in the same cycle
      do_reset();
      req = 3'b001; ack = 1'b1;
      cycle();
      req = 3'b010;
      cycle();
      chk("t5_pend011", dut.pending_q, 3'b011);
      req = 3'b100; rvld = 1'b1; rid = 4'd1;
      cycle();
      chk("t5_rtrn", obs_rtrn, 3'b001);
      chk("t5_pending", dut.pending_q, 3'b110);

      // 6: reset while locked with misses outstanding
      do_reset();
      req = 3'b001; ack = 1'b1;
      cycle();
      req = 3'b100;
      cycle();
      req = 3'b010; ack = 1'b0;
      cycle();
      chk("t6_pend101", dut.pending_q, 3'b101);
      do_reset();
      rvld = 1'b1; rid = 4'd3;
      cycle();
      chk("t6_stale_rtrn", obs_rtrn, 3'b000);

      // randomized traffic obeying the requester contract
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         rand_fields();
         ack  = ($urandom_range(0, 2) == 0);
         rep  = ($urandom_range(0, 5) == 0);
         rvld = 1'b0; rid = '0;
         if (m_pend != '0 && $urandom_range(0, 2) == 0) begin
            int p;
            p = $urandom_range(0, N - 1);
            while (!m_pend[p]) p = (p + 1) % N;
            rvld = 1'b1; rid = TidW'(1 + p);
         end
         cycle();
         req = req & ~(last_ack | last_rep);
         for (int i = 0; i < N; i++)
            if (!req[i] && !m_pend[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
